// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the hazard/stall sequencer and the operand forwarding unit.
package hazard_stall_controller_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hsc_state_e;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter: advances on each enabled edge and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use bubbles, mult/div front-end freeze,
// memory wait-state freeze and taken-branch squash, plus a stall-cycle counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MD_LATENCY     = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_usesRs,
    input  logic                      id_usesRt,
    input  logic                      ex_memRead,
    input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
    input  logic                      ex_branchTaken,
    input  logic                      ex_mdStart,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_stall,
    output logic                      ifid_stall,
    output logic                      idex_stall,
    output logic                      exmem_stall,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      exmem_flush,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [CNT_WIDTH-1:0]      stallCycles
);

    localparam int MD_CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

    hsc_state_e       state_q, state_d;
    logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = mem_req & ~mem_ready;
    assign load_use = ex_memRead
                    && (ex_regToWrite != REG_ADDR_WIDTH'(ZERO_REG))
                    && ((id_usesRs && (id_rs == ex_regToWrite))
                     || (id_usesRt && (id_rt == ex_regToWrite)));

    // The mult/div unit runs on regardless of memWait, so the countdown is not gated by it.
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        if (state_q == MD_BUSY) begin
            if (md_cnt_q == '0) begin
                state_d   = RUN;
                md_done_d = 1'b1;
            end else begin
                md_cnt_d = md_cnt_q - MD_CW'(1);
            end
        end else if (!mem_wait && ex_mdStart) begin
            state_d  = MD_BUSY;
            md_cnt_d = MD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (state_q == MD_BUSY) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
            end else if (ex_branchTaken) begin
                // Squashing the ID instruction also removes any load-use dependency it had.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign md_busy = (state_q == MD_BUSY) && !rst;
    assign md_done = md_done_q;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (pc_stall),
        .count_o (stallCycles)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with a queue of expected output vectors.
module tb_hazard_stall_controller;

    localparam int RW  = 5;
    localparam int MDL = 4;
    localparam int CW  = 4;

    // Expected vector bit order: pc ifid idex exmem | ifid_f idex_f exmem_f | md_busy md_done
    localparam logic [8:0] E_NONE = 9'b0000_000_00;
    localparam logic [8:0] E_LU   = 9'b1100_010_00;
    localparam logic [8:0] E_BR   = 9'b0000_110_00;
    localparam logic [8:0] E_MD   = 9'b1110_001_10;
    localparam logic [8:0] E_MW   = 9'b1111_000_00;
    localparam logic [8:0] E_MWB  = 9'b1111_000_10;
    localparam logic [8:0] E_MWD  = 9'b1111_000_01;
    localparam logic [8:0] E_DONE = 9'b0000_000_01;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_regToWrite;
    logic          id_usesRs, id_usesRt, ex_memRead, ex_branchTaken, ex_mdStart;
    logic          mem_req, mem_ready;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic          ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
    logic [CW-1:0] stallCycles;

    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [8:0]    exp_q[$];

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .REG_ADDR_WIDTH (RW),
        .MD_LATENCY     (MDL),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_usesRs      (id_usesRs),
        .id_usesRt      (id_usesRt),
        .ex_memRead     (ex_memRead),
        .ex_regToWrite  (ex_regToWrite),
        .ex_branchTaken (ex_branchTaken),
        .ex_mdStart     (ex_mdStart),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .idex_stall     (idex_stall),
        .exmem_stall    (exmem_stall),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .stallCycles    (stallCycles)
    );

    task automatic drv(input logic mr, input logic [RW-1:0] rw, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic urs, input logic urt,
                       input logic br, input logic mds, input logic mq, input logic mrdy);
        ex_memRead     = mr;
        ex_regToWrite  = rw;
        id_rs          = rs;
        id_rt          = rt;
        id_usesRs      = urs;
        id_usesRt      = urt;
        ex_branchTaken = br;
        ex_mdStart     = mds;
        mem_req        = mq;
        mem_ready      = mrdy;
    endtask

    task automatic idle();
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge: push expectation, let outputs settle, compare, advance one cycle.
    task automatic chk(input string tag, input logic [8:0] e);
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        exp_q.push_back(e);
        #2;
        exp_v = exp_q.pop_front();
        obs_v = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                 ifid_flush, idex_flush, exmem_flush, md_busy, md_done};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
        end
        checks++;
        assert (stallCycles === exp_cnt) else begin
            failures++;
            $error("FAIL %s stallCycles observed=%0d expected=%0d", tag, stallCycles, exp_cnt);
        end
        if (exp_v[8] && !rst && (exp_cnt != '1)) exp_cnt = exp_cnt + CW'(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mem_req = 1'b1;
        #1;
        chk("reset_forced", E_NONE);
        rst = 1'b0;
        idle();
        chk("idle", E_NONE);

        drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs", E_LU);
        idle();
        chk("lu_clear", E_NONE);
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_r0", E_NONE);
        drv(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_unused", E_NONE);
        drv(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rt", E_LU);
        drv(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br_over_lu", E_BR);

        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("md_start", E_NONE);
        chk("md_busy1", E_MD);
        chk("md_busy2_start_ignored", E_MD);
        idle();
        chk("md_busy3", E_MD);
        chk("md_busy4", E_MD);
        chk("md_done", E_DONE);
        chk("md_after", E_NONE);

        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) chk("memwait_br", E_MW);
        mem_ready = 1'b1;
        chk("br_after_wait", E_BR);

        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("md2_start", E_NONE);
        idle();
        for (int i = 0; i < 3; i++) chk("md2_busy", E_MD);
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("md2_busy_memwait", E_MWB);
        chk("md2_done_memwait", E_MWD);
        idle();
        chk("md2_after", E_NONE);

        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("md3_start", E_NONE);
        idle();
        chk("md3_busy", E_MD);
        drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        exp_cnt = '0;
        chk("async_reset", E_NONE);
        rst = 1'b0;
        idle();
        chk("post_reset", E_NONE);

        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < (1 << CW) + 2; i++) chk("saturate", E_MW);
        idle();
        chk("sat_hold", E_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
